// File: rtl/mem_access_unit.sv
`default_nettype none
//==============================================================================
// Module   : mem_access_unit
// Brief    : MEM pipeline stage. Runs loads/stores on a req/addr_ok/data_ok bus,
//            extracts load data and registers write-back fields for MEM->WB.
//            Optional macro MEM_MISALIGN_EXC_EN: misaligned-access exception
//            (exc_o/badvaddr_o) instead of forced address alignment.
// Revision : 1.0 - initial release
//==============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic [4:0]        ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_we_i,
    input  logic [3:0]        ex_memop_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_sdata_i,
    output logic              stall_o,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_wstrb_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              wb_we_o
`ifdef MEM_MISALIGN_EXC_EN
    ,
    output logic              exc_o,
    output logic [ADDR_W-1:0] badvaddr_o
`endif
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    localparam logic [1:0] c_SIZE_B = 2'd0;
    localparam logic [1:0] c_SIZE_H = 2'd1;
    localparam logic [1:0] c_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_req_addr;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic              w_accept;
    logic              w_exc;
    logic              w_start_req;
    logic              w_imm_valid;
    logic              w_done;

    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_req_wdata;
    logic [3:0]        r_memop;
    logic              r_we;
    logic [4:0]        r_waddr;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_cmp_wdata;
    logic              w_cmp_we;
    logic [DATA_W-1:0] w_imm_wdata;
    logic              w_imm_we;

    logic              r_pend_valid;
    logic [4:0]        r_pend_waddr;
    logic [DATA_W-1:0] r_pend_wdata;
    logic              r_pend_we;
`ifdef MEM_MISALIGN_EXC_EN
    logic              r_pend_exc;
    logic [ADDR_W-1:0] r_pend_badvaddr;
    logic              w_misalign;
`endif

    // Memory-op decode; unknown encodings behave as NONE.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = c_SIZE_B;
        case (ex_memop_i)
            c_OP_LB, c_OP_LBU: begin w_is_load  = 1'b1; w_size = c_SIZE_B; end
            c_OP_LH, c_OP_LHU: begin w_is_load  = 1'b1; w_size = c_SIZE_H; end
            c_OP_LW:           begin w_is_load  = 1'b1; w_size = c_SIZE_W; end
            c_OP_SB:           begin w_is_store = 1'b1; w_size = c_SIZE_B; end
            c_OP_SH:           begin w_is_store = 1'b1; w_size = c_SIZE_H; end
            c_OP_SW:           begin w_is_store = 1'b1; w_size = c_SIZE_W; end
            default: ;
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;

`ifdef MEM_MISALIGN_EXC_EN
    assign w_misalign = ((w_size == c_SIZE_H) && ex_addr_i[0]) ||
                        ((w_size == c_SIZE_W) && (ex_addr_i[1:0] != 2'b00));
    assign w_exc      = w_accept && w_is_mem && w_misalign;
    // Misaligned accesses never reach the bus, so no alignment is applied.
    assign w_req_addr = ex_addr_i;
`else
    assign w_exc = 1'b0;
    always_comb begin
        w_req_addr = ex_addr_i;
        if (w_size == c_SIZE_H) begin
            w_req_addr[0] = 1'b0;
        end else if (w_size == c_SIZE_W) begin
            w_req_addr[1:0] = 2'b00;
        end
    end
`endif

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = '0;
        if (w_is_store) begin
            case (w_size)
                c_SIZE_B: begin
                    w_wstrb = 4'b0001 << w_req_addr[1:0];
                    w_wdata = {4{ex_sdata_i[7:0]}};
                end
                c_SIZE_H: begin
                    w_wstrb = w_req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{ex_sdata_i[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = ex_sdata_i;
                end
            endcase
        end
    end

    // Completion cycle releases the stall so the next op can enter back-to-back.
    assign stall_o     = (r_state == S_REQ) || ((r_state == S_WAIT) && !data_data_ok_i);
    assign w_accept    = ex_valid_i && !stall_o;
    assign w_start_req = w_accept && w_is_mem && !w_exc;
    assign w_imm_valid = w_accept && !w_start_req;
    assign w_done      = ((r_state == S_REQ) && data_addr_ok_i && data_data_ok_i) ||
                         ((r_state == S_WAIT) && data_data_ok_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) w_state_nx = S_REQ;
            end
            S_REQ: begin
                if (data_addr_ok_i) w_state_nx = data_data_ok_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (data_data_ok_i) w_state_nx = w_start_req ? S_REQ : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Captured request; only reloaded when a new access starts, so it is stable until addr_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wstrb     <= 4'b0000;
            r_req_wdata <= '0;
            r_memop     <= 4'd0;
            r_we        <= 1'b0;
            r_waddr     <= 5'd0;
        end else if (w_start_req) begin
            r_wr        <= w_is_store;
            r_size      <= w_size;
            r_addr      <= w_req_addr;
            r_wstrb     <= w_wstrb;
            r_req_wdata <= w_wdata;
            r_memop     <= ex_memop_i;
            r_we        <= ex_we_i;
            r_waddr     <= ex_waddr_i;
        end
    end

    assign data_req_o   = (r_state == S_REQ);
    assign data_wr_o    = r_wr;
    assign data_size_o  = r_size;
    assign data_addr_o  = r_addr;
    assign data_wstrb_o = r_wstrb;
    assign data_wdata_o = r_req_wdata;

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = data_rdata_i[7:0];
            2'd1:    w_byte = data_rdata_i[15:8];
            2'd2:    w_byte = data_rdata_i[23:16];
            default: w_byte = data_rdata_i[31:24];
        endcase
        w_half = r_addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (r_memop)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'd0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = data_rdata_i;
        endcase
    end

    assign w_cmp_wdata = r_wr ? '0 : w_load_data;
    assign w_cmp_we    = r_wr ? 1'b0 : r_we;
    assign w_imm_wdata = w_exc ? '0 : ex_wdata_i;
    assign w_imm_we    = w_exc ? 1'b0 : ex_we_i;

    // A completing access owns the next WB slot; an op accepted alongside it (or behind a
    // pending one) is parked one cycle in the pending slot to keep program order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o      <= 1'b0;
            wb_waddr_o      <= 5'd0;
            wb_wdata_o      <= '0;
            wb_we_o         <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_pend_waddr    <= 5'd0;
            r_pend_wdata    <= '0;
            r_pend_we       <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            exc_o           <= 1'b0;
            badvaddr_o      <= '0;
            r_pend_exc      <= 1'b0;
            r_pend_badvaddr <= '0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            exc_o      <= 1'b0;
`endif
            if (w_done) begin
                wb_valid_o <= 1'b1;
                wb_waddr_o <= r_waddr;
                wb_wdata_o <= w_cmp_wdata;
                wb_we_o    <= w_cmp_we;
            end else if (r_pend_valid) begin
                wb_valid_o <= 1'b1;
                wb_waddr_o <= r_pend_waddr;
                wb_wdata_o <= r_pend_wdata;
                wb_we_o    <= r_pend_we;
`ifdef MEM_MISALIGN_EXC_EN
                exc_o      <= r_pend_exc;
                if (r_pend_exc) badvaddr_o <= r_pend_badvaddr;
`endif
            end else if (w_imm_valid) begin
                wb_valid_o <= 1'b1;
                wb_waddr_o <= ex_waddr_i;
                wb_wdata_o <= w_imm_wdata;
                wb_we_o    <= w_imm_we;
`ifdef MEM_MISALIGN_EXC_EN
                exc_o      <= w_exc;
                if (w_exc) badvaddr_o <= ex_addr_i;
`endif
            end

            if (w_done || r_pend_valid) begin
                r_pend_valid    <= w_imm_valid;
                r_pend_waddr    <= ex_waddr_i;
                r_pend_wdata    <= w_imm_wdata;
                r_pend_we       <= w_imm_we;
`ifdef MEM_MISALIGN_EXC_EN
                r_pend_exc      <= w_exc;
                r_pend_badvaddr <= ex_addr_i;
`endif
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for mem_access_unit: directed ops, bus responder driven by an expected-request
// queue, and a write-back monitor popping an expected-result scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_we_i;
    logic [3:0]  ex_memop_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_sdata_i;
    logic        stall_o;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_we_o;
`ifdef MEM_MISALIGN_EXC_EN
    logic        exc_o;
    logic [31:0] badvaddr_o;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_we_i(ex_we_i), .ex_memop_i(ex_memop_i), .ex_addr_i(ex_addr_i),
        .ex_sdata_i(ex_sdata_i), .stall_o(stall_o),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
        .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
        .wb_we_o(wb_we_o)
`ifdef MEM_MISALIGN_EXC_EN
        , .exc_o(exc_o), .badvaddr_o(badvaddr_o)
`endif
    );

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          adly;
        int          ddly;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int wb_count = 0;
    int req_count = 0;
    int stall_cycles = 0;
    int cyc = 0;
    int last_dok = -100;
    int gap = 0;
    bit bus_auto = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic [4:0] wa, input logic [31:0] wd, input logic we);
        wb_t e;
        e.waddr = wa; e.wdata = wd; e.we = we;
        wb_q.push_back(e);
    endtask

    task automatic exp_req(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                           input logic [3:0] strb, input logic [31:0] wd,
                           input logic [31:0] rd, input int adly, input int ddly);
        req_t r;
        r.addr = addr; r.size = size; r.wr = wr; r.wstrb = strb; r.wdata = wd;
        r.rdata = rd; r.adly = adly; r.ddly = ddly;
        req_q.push_back(r);
    endtask

    // Present one op and hold it until accepted; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [4:0] wa, input logic [31:0] wd,
                         input logic we, input logic [31:0] addr, input logic [31:0] sd);
        int n;
        n = 0;
        ex_valid_i = 1'b1; ex_memop_i = op; ex_waddr_i = wa; ex_wdata_i = wd;
        ex_we_i = we; ex_addr_i = addr; ex_sdata_i = sd;
        @(negedge clk);
        while (stall_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: stall_o still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        ex_memop_i = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Write-back monitor
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (stall_o === 1'b1) stall_cycles++;
            if (rst === 1'b0 && wb_valid_o === 1'b1) begin
                wb_count++;
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got pulse waddr=%0d wdata=0x%08h, required none",
                             wb_waddr_o, wb_wdata_o);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_waddr", 32'(wb_waddr_o), 32'(e.waddr));
                    check("wb_wdata", wb_wdata_o, e.wdata);
                    check("wb_we", 32'(wb_we_o), 32'(e.we));
                end
            end
        end
    end

    // Bus responder: pops one expected request per access and plays its timing.
    initial begin
        req_t cur;
        int   cnt;
        int   bst;
        bst = 0;
        cnt = 0;
        cur = '{default: 0};
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (bus_auto) begin
                data_addr_ok_i = 1'b0;
                data_data_ok_i = 1'b0;
                data_rdata_i   = 32'h5A5A5A5A;
                if (bst == 0 && data_req_o === 1'b1) begin
                    req_count++;
                    gap = cyc - last_dok;
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL bus_req_unexpected: got request addr 0x%08h, required none",
                                 data_addr_o);
                        cur = '{default: 0};
                    end else begin
                        cur = req_q.pop_front();
                    end
                    bst = 1;
                    cnt = cur.adly;
                end
                if (bst == 1) begin
                    if (cnt == 0) begin
                        check("req_addr", data_addr_o, cur.addr);
                        check("req_size", 32'(data_size_o), 32'(cur.size));
                        check("req_wr", 32'(data_wr_o), 32'(cur.wr));
                        check("req_wstrb", 32'(data_wstrb_o), 32'(cur.wstrb));
                        check("req_wdata", data_wdata_o, cur.wdata);
                        data_addr_ok_i = 1'b1;
                        if (cur.ddly == 0) begin
                            data_data_ok_i = 1'b1;
                            data_rdata_i   = cur.rdata;
                            last_dok = cyc;
                            bst = 0;
                        end else begin
                            bst = 2;
                            cnt = cur.ddly - 1;
                        end
                    end else begin
                        cnt--;
                    end
                end else if (bst == 2) begin
                    if (cnt == 0) begin
                        data_data_ok_i = 1'b1;
                        data_rdata_i   = cur.rdata;
                        last_dok = cyc;
                        bst = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int wc;
        rst = 1'b1;
        ex_valid_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0; ex_we_i = 1'b0;
        ex_memop_i = 4'd0; ex_addr_i = 32'd0; ex_sdata_i = 32'd0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_we", 32'(wb_we_o), 32'd0);
        check("rst_wb_waddr", 32'(wb_waddr_o), 32'd0);
        check("rst_wb_wdata", wb_wdata_o, 32'd0);
        check("rst_req", 32'(data_req_o), 32'd0);
        check("rst_wr", 32'(data_wr_o), 32'd0);
        check("rst_size", 32'(data_size_o), 32'd0);
        check("rst_addr", data_addr_o, 32'd0);
        check("rst_wstrb", 32'(data_wstrb_o), 32'd0);
        check("rst_wdata", data_wdata_o, 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
`ifdef MEM_MISALIGN_EXC_EN
        check("rst_exc", 32'(exc_o), 32'd0);
        check("rst_badvaddr", badvaddr_o, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // 1: ALU op passes through with latency 1 and no bus request
        rc = req_count;
        exp_wb(5'd3, 32'h0000_1234, 1'b1);
        issue(4'd0, 5'd3, 32'h0000_1234, 1'b1, 32'h0000_0040, 32'd0);
        @(negedge clk);
        check("t1_latency_wb_valid", 32'(wb_valid_o), 32'd1);
        idle(2);
        check("t1_no_req", 32'(req_count - rc), 32'd0);

        // 2: LB 0x103, addr_ok+data_ok together, one stall cycle
        stall_cycles = 0;
        exp_req(32'h0000_0103, 2'd0, 1'b0, 4'b0000, 32'd0, 32'h80FF_0000, 0, 0);
        exp_wb(5'd5, 32'hFFFF_FF80, 1'b1);
        issue(4'd1, 5'd5, 32'd0, 1'b1, 32'h0000_0103, 32'd0);
        idle(4);
        check("t2_stall_cycles", 32'(stall_cycles), 32'd1);

        // 3: SH 0x102, addr_ok after 2 cycles, data_ok 3 later
        stall_cycles = 0;
        exp_req(32'h0000_0102, 2'd1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'd0, 2, 3);
        exp_wb(5'd7, 32'd0, 1'b0);
        issue(4'd7, 5'd7, 32'hFFFF_FFFF, 1'b1, 32'h0000_0102, 32'h0000_ABCD);
        idle(10);
        check("t3_stall_cycles", 32'(stall_cycles), 32'd5);

        // 4: LW then LHU back-to-back
        exp_req(32'h0000_0200, 2'd2, 1'b0, 4'b0000, 32'd0, 32'h1122_3344, 0, 2);
        exp_wb(5'd8, 32'h1122_3344, 1'b1);
        exp_req(32'h0000_0206, 2'd1, 1'b0, 4'b0000, 32'd0, 32'h8001_0000, 1, 0);
        exp_wb(5'd9, 32'h0000_8001, 1'b1);
        issue(4'd5, 5'd8, 32'd0, 1'b1, 32'h0000_0200, 32'd0);
        issue(4'd4, 5'd9, 32'd0, 1'b1, 32'h0000_0206, 32'd0);
        idle(6);
        check("t4_req_gap", 32'(gap), 32'd1);

        // 5: reset while waiting for data_ok; stray data_ok afterwards
        bus_auto = 1'b0;
        wc = wb_count;
        issue(4'd5, 5'd10, 32'd0, 1'b1, 32'h0000_0300, 32'd0);
        data_addr_ok_i = 1'b1;
        @(negedge clk);
        check("t5_req_addr", data_addr_o, 32'h0000_0300);
        @(posedge clk); #1;
        data_addr_ok_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_wait_stall", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_req", 32'(data_req_o), 32'd0);
        check("t5_rst_stall", 32'(stall_o), 32'd0);
        check("t5_rst_addr", data_addr_o, 32'd0);
        @(posedge clk); #1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t5_stray_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        data_data_ok_i = 1'b0;
        idle(3);
        check("t5_no_wb", 32'(wb_count - wc), 32'd0);
        check("t5_idle_req", 32'(data_req_o), 32'd0);
        bus_auto = 1'b1;
        idle(1);

        // 6: misaligned LW at 0x101
        rc = req_count;
`ifdef MEM_MISALIGN_EXC_EN
        exp_wb(5'd11, 32'd0, 1'b0);
        issue(4'd5, 5'd11, 32'h0000_9999, 1'b1, 32'h0000_0101, 32'd0);
        @(negedge clk);
        check("t6_exc", 32'(exc_o), 32'd1);
        check("t6_badvaddr", badvaddr_o, 32'h0000_0101);
        idle(3);
        check("t6_no_req", 32'(req_count - rc), 32'd0);
`else
        exp_req(32'h0000_0100, 2'd2, 1'b0, 4'b0000, 32'd0, 32'hCAFE_F00D, 0, 0);
        exp_wb(5'd11, 32'hCAFE_F00D, 1'b1);
        issue(4'd5, 5'd11, 32'h0000_9999, 1'b1, 32'h0000_0101, 32'd0);
        idle(3);
        check("t6_one_req", 32'(req_count - rc), 32'd1);
`endif

        // 7: extra lanes and ops
        exp_req(32'h0000_0101, 2'd0, 1'b0, 4'b0000, 32'd0, 32'h0000_A500, 0, 1);
        exp_wb(5'd12, 32'h0000_00A5, 1'b1);
        issue(4'd2, 5'd12, 32'd0, 1'b1, 32'h0000_0101, 32'd0);
        exp_req(32'h0000_0100, 2'd1, 1'b0, 4'b0000, 32'd0, 32'h0000_8765, 1, 1);
        exp_wb(5'd13, 32'hFFFF_8765, 1'b1);
        issue(4'd3, 5'd13, 32'd0, 1'b1, 32'h0000_0100, 32'd0);
        exp_req(32'h0000_0301, 2'd0, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'd0, 0, 0);
        exp_wb(5'd14, 32'd0, 1'b0);
        issue(4'd6, 5'd14, 32'd0, 1'b1, 32'h0000_0301, 32'h1234_565A);
        exp_req(32'h0000_0304, 2'd2, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1, 2);
        exp_wb(5'd15, 32'd0, 1'b0);
        issue(4'd8, 5'd15, 32'd0, 1'b1, 32'h0000_0304, 32'hDEAD_BEEF);
        // ALU op accepted in the completion cycle must follow the load in WB order
        exp_req(32'h0000_0400, 2'd2, 1'b0, 4'b0000, 32'd0, 32'h0BAD_F00D, 0, 1);
        exp_wb(5'd16, 32'h0BAD_F00D, 1'b1);
        exp_wb(5'd17, 32'h0000_0055, 1'b1);
        issue(4'd5, 5'd16, 32'd0, 1'b1, 32'h0000_0400, 32'd0);
        issue(4'd0, 5'd17, 32'h0000_0055, 1'b1, 32'd0, 32'd0);
        // Undefined memop encoding behaves as NONE
        exp_wb(5'd18, 32'h0000_0077, 1'b0);
        issue(4'd9, 5'd18, 32'h0000_0077, 1'b0, 32'h0000_0500, 32'd0);
        idle(8);

        check("end_wb_queue_empty", 32'(wb_q.size()), 32'd0);
        check("end_req_queue_empty", 32'(req_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
